// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset multi-cycle core
module multicycle_control #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_WIDTH  = 3,
  parameter int IMM_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  alu_zero,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic                  alu_src_b,
  output logic [ALU_WIDTH-1:0]  alu_ctrl,
  output logic [IMM_WIDTH-1:0]  imm_src,
  output logic                  retire,
  output logic                  trap
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
  localparam logic [ALU_WIDTH-1:0] SUM = 0, SUB = 1, AND = 2, SLT = 3, SLL = 4;
  localparam logic [IMM_WIDTH-1:0] IMM = 0, STORE = 1, BRANCH = 2, UPPER = 3, JUMP = 4;
  logic [2:0] state_q, state_d;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic is_r, is_i1, is_i2, is_i3, is_s, is_b, is_u1, is_u2, is_j;
  logic alu_legal, illegal, taken, unused;
  logic [ALU_WIDTH-1:0] alu_op;
  logic [IMM_WIDTH-1:0] imm_fmt;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign unused = ^instr[24:15];
  assign is_r   = opcode == 7'b0110011;
  assign is_i2  = opcode == 7'b0010011;
  assign is_i1  = opcode == 7'b0000011;
  assign is_s   = opcode == 7'b0100011;
  assign is_b   = opcode == 7'b1100011;
  assign is_u1  = opcode == 7'b0010111;
  assign is_u2  = opcode == 7'b0110111;
  assign is_j   = opcode == 7'b1101111;
  assign is_i3  = opcode == 7'b1100111;
  assign alu_legal = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b010 || (f3 == 3'b001 && f7 == 7'd0);
  assign illegal = !(is_r | is_i1 | is_i2 | is_i3 | is_s | is_b | is_u1 | is_u2 | is_j)
                 || ((is_r | is_i2) && !alu_legal) || ((is_i1 | is_s) && f3 != 3'b010);
  assign alu_op  = f3 == 3'b000 ? ((is_r && f7[5]) ? SUB : SUM) :
                   f3 == 3'b111 ? AND : f3 == 3'b010 ? SLT : SLL;
  assign imm_fmt = is_s ? STORE : is_b ? BRANCH : (is_u1 | is_u2) ? UPPER : is_j ? JUMP : IMM;
  assign taken   = (f3 == 3'b000 && alu_zero) || (f3 == 3'b001 && !alu_zero);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ack ? DECODE : FETCH;
      DECODE:  state_d = illegal ? TRAP : EXEC;
      EXEC:    state_d = is_b ? FETCH : (is_i1 | is_s) ? MEM : WB;
      MEM:     state_d = mem_ack ? (is_s ? FETCH : WB) : MEM;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? FETCH : state_d;
  // Everything is decoded straight from the state register, so reset must mask it explicitly.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; addr_src = 1'b0; ir_write = 1'b0;
    pc_write = 1'b0; pc_src = 2'b00; reg_write = 1'b0; result_src = 2'b00;
    alu_src_a = 1'b0; alu_src_b = 1'b0; alu_ctrl = SUM; imm_src = IMM;
    retire = 1'b0; trap = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
        end
        DECODE: imm_src = imm_fmt;
        EXEC: begin
          imm_src   = imm_fmt;
          alu_src_a = is_u1;
          alu_src_b = is_i2 | is_i1 | is_s | is_u1 | is_i3;
          alu_ctrl  = (is_r | is_i2) ? alu_op : is_b ? SUB : SUM;
          pc_write  = is_b;
          retire    = is_b;
          pc_src    = {1'b0, is_b & taken};
        end
        MEM: begin
          imm_src  = imm_fmt;
          mem_req  = 1'b1;
          addr_src = 1'b1;
          mem_we   = is_s;
          pc_write = is_s & mem_ack;
          retire   = is_s & mem_ack;
        end
        WB: begin
          imm_src    = imm_fmt;
          reg_write  = instr[11:7] != 5'd0;
          pc_write   = 1'b1;
          retire     = 1'b1;
          result_src = is_i1 ? 2'b01 : (is_j | is_i3) ? 2'b10 : is_u2 ? 2'b11 : 2'b00;
          pc_src     = is_j ? 2'b01 : is_i3 ? 2'b10 : 2'b00;
        end
        TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle vector table plus a hand-written FETCH-stall sequence
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, alu_zero = 1'b0, mem_ack = 1'b0;
  logic [31:0] instr = 32'd0;
  logic mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, alu_src_a, alu_src_b, retire, trap;
  logic [1:0] pc_src, result_src;
  logic [2:0] alu_ctrl, imm_src;
  logic [19:0] outs;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
    .retire(retire), .trap(trap)
  );
  assign outs = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_ctrl, imm_src, retire, trap};
  localparam logic [19:0] MREQ = 20'h80000, MWE = 20'h40000, ASRC = 20'h20000, IRW = 20'h10000,
                          PCW = 20'h08000, RW = 20'h01000, SA = 20'h00200, SB = 20'h00100,
                          RET = 20'h00002, TRP = 20'h00001, ALL = 20'hFFFFF, NOIMM = 20'hFFFE3;
  localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0080A283, BEQ = 32'h00208863,
                          BNE = 32'h00209863, SUBX0 = 32'h40208033, ANDI = 32'h00517093,
                          SW = 32'h0020A223, JAL = 32'h008000EF, LUI = 32'h123452B7,
                          AUIPC = 32'h00001297, JALR = 32'h000280E7, ILL = 32'h0000007F,
                          XORR = 32'h0020C1B3, LB = 32'h00008283;
  function automatic logic [19:0] pcs(logic [1:0] x); return 20'(x) << 13; endfunction
  function automatic logic [19:0] res(logic [1:0] x); return 20'(x) << 10; endfunction
  function automatic logic [19:0] alu(logic [2:0] x); return 20'(x) << 5; endfunction
  function automatic logic [19:0] imm(logic [2:0] x); return 20'(x) << 2; endfunction
  typedef struct {
    string n; logic r; logic [31:0] i; logic z; logic a; logic [19:0] e; logic [19:0] c;
  } vec_t;
  vec_t vq[$];
  task automatic v(string n, logic r, logic [31:0] i, logic z, logic a, logic [19:0] e, logic [19:0] c = ALL);
    vq.push_back('{n, r, i, z, a, e, c});
  endtask
  task automatic chk(string n, logic [19:0] e, logic [19:0] c);
    tests++;
    if ((outs & c) !== (e & c)) begin
      fails++;
      $display("FAIL %s: outputs %05h, expected %05h (mask %05h)", n, outs & c, e & c, c);
    end
  endtask
  task automatic step(logic r, logic [31:0] i, logic z, logic a);
    rst = r; instr = i; alu_zero = z; mem_ack = a;
  endtask
  initial begin
    v("rst0", 1, 0, 0, 0, 0); v("rst1", 1, 0, 0, 1, 0); v("rst2", 1, 0, 0, 0, 0);
    v("add.f", 0, ADD, 0, 1, MREQ | IRW); v("add.d", 0, ADD, 0, 0, 0);
    v("add.e", 0, ADD, 0, 0, 0); v("add.w", 0, ADD, 0, 0, RW | PCW | RET, NOIMM);
    v("lw.f", 0, LW, 0, 1, MREQ | IRW); v("lw.d", 0, LW, 0, 0, 0); v("lw.e", 0, LW, 0, 0, SB);
    v("lw.m0", 0, LW, 0, 0, MREQ | ASRC, NOIMM); v("lw.m1", 0, LW, 0, 0, MREQ | ASRC, NOIMM);
    v("lw.m2", 0, LW, 0, 1, MREQ | ASRC, NOIMM);
    v("lw.w", 0, LW, 0, 0, RW | PCW | RET | res(1), NOIMM);
    v("beq1.f", 0, BEQ, 0, 1, MREQ | IRW); v("beq1.d", 0, BEQ, 1, 0, imm(2));
    v("beq1.e", 0, BEQ, 1, 0, PCW | RET | pcs(1) | alu(1) | imm(2));
    v("beq0.fw", 0, BEQ, 0, 0, MREQ); v("beq0.f", 0, BEQ, 0, 1, MREQ | IRW);
    v("beq0.d", 0, BEQ, 0, 0, imm(2)); v("beq0.e", 0, BEQ, 0, 0, PCW | RET | alu(1) | imm(2));
    v("bne.f", 0, BNE, 0, 1, MREQ | IRW); v("bne.d", 0, BNE, 0, 0, imm(2));
    v("bne.e", 0, BNE, 0, 0, PCW | RET | pcs(1) | alu(1) | imm(2));
    v("sub.f", 0, SUBX0, 0, 1, MREQ | IRW); v("sub.d", 0, SUBX0, 0, 1, 0);
    v("sub.e", 0, SUBX0, 0, 1, alu(1)); v("sub.w", 0, SUBX0, 0, 0, PCW | RET, NOIMM);
    v("andi.f", 0, ANDI, 0, 1, MREQ | IRW); v("andi.d", 0, ANDI, 0, 0, 0);
    v("andi.e", 0, ANDI, 0, 0, SB | alu(2)); v("andi.w", 0, ANDI, 0, 0, RW | PCW | RET, NOIMM);
    v("sw.f", 0, SW, 0, 1, MREQ | IRW); v("sw.d", 0, SW, 0, 0, imm(1));
    v("sw.e", 0, SW, 0, 0, SB | imm(1));
    v("sw.m", 0, SW, 0, 1, MREQ | MWE | ASRC | PCW | RET, NOIMM);
    v("jal.f", 0, JAL, 0, 1, MREQ | IRW); v("jal.d", 0, JAL, 0, 0, imm(4));
    v("jal.e", 0, JAL, 0, 0, imm(4));
    v("jal.w", 0, JAL, 0, 0, RW | PCW | RET | res(2) | pcs(1), NOIMM);
    v("lui.f", 0, LUI, 0, 1, MREQ | IRW); v("lui.d", 0, LUI, 0, 0, imm(3));
    v("lui.e", 0, LUI, 0, 0, imm(3)); v("lui.w", 0, LUI, 0, 0, RW | PCW | RET | res(3), NOIMM);
    v("auipc.f", 0, AUIPC, 0, 1, MREQ | IRW); v("auipc.d", 0, AUIPC, 0, 0, imm(3));
    v("auipc.e", 0, AUIPC, 0, 0, SA | SB | imm(3));
    v("auipc.w", 0, AUIPC, 0, 0, RW | PCW | RET, NOIMM);
    v("jalr.f", 0, JALR, 0, 1, MREQ | IRW); v("jalr.d", 0, JALR, 0, 0, 0);
    v("jalr.e", 0, JALR, 0, 0, SB);
    v("jalr.w", 0, JALR, 0, 0, RW | PCW | RET | res(2) | pcs(2), NOIMM);
    v("ill.f", 0, ILL, 0, 1, MREQ | IRW); v("ill.d", 0, ILL, 0, 0, 0, NOIMM);
    for (int k = 0; k < 10; k++) v($sformatf("ill.trap%0d", k), 0, ILL, k[0], 1, TRP);
    v("ill.rst", 1, ILL, 0, 0, 0);
    v("xor.f", 0, XORR, 0, 1, MREQ | IRW); v("xor.d", 0, XORR, 0, 0, 0);
    v("xor.trap", 0, XORR, 0, 0, TRP); v("xor.rst", 1, XORR, 0, 0, 0);
    v("lb.f", 0, LB, 0, 1, MREQ | IRW); v("lb.d", 0, LB, 0, 0, 0);
    v("lb.trap", 0, LB, 0, 0, TRP); v("lb.rst", 1, LB, 0, 0, 0);
    v("swr.f", 0, SW, 0, 1, MREQ | IRW); v("swr.d", 0, SW, 0, 0, imm(1));
    v("swr.e", 0, SW, 0, 0, SB | imm(1)); v("swr.m", 0, SW, 0, 0, MREQ | MWE | ASRC, NOIMM);
    v("swr.rst0", 1, SW, 0, 1, 0); v("swr.rst1", 1, SW, 0, 1, 0);
    v("swr.fetch", 0, SW, 0, 0, MREQ);
    #1;
    foreach (vq[k]) begin
      step(vq[k].r, vq[k].i, vq[k].z, vq[k].a);
      @(negedge clk) chk(vq[k].n, vq[k].e, vq[k].c);
      @(posedge clk) #1;
    end
    // A long fetch stall must hold the request without loading the IR, then decode normally.
    for (int k = 0; k < 5; k++) begin
      step(0, ADD, 0, 0);
      @(negedge clk) chk($sformatf("stall%0d", k), MREQ, ALL);
      @(posedge clk) #1;
    end
    step(0, ADD, 0, 1);
    @(negedge clk) chk("stall.ack", MREQ | IRW, ALL);
    @(posedge clk) #1;
    step(0, ADD, 0, 0);
    @(negedge clk) chk("stall.decode", 0, ALL);
    @(posedge clk) #1;
    @(negedge clk) chk("stall.exec", 0, ALL);
    @(posedge clk) #1;
    @(negedge clk) chk("stall.wb", RW | PCW | RET, NOIMM);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I-subset core. It sequences one shared memory port, the ALU, the register file and the PC through FETCH/DECODE/EXEC/MEM/WB.
- It decodes the opcode, ALU command and immediate-format encodings defined in types_pkg.
- It sits between the instruction register and the datapath muxes. It is the sole owner of every datapath write-enable.

Parameters:
- DATA_WIDTH, 32, instruction/data width (from types_pkg)
- ALU_WIDTH, 3, alu_ctrl width (from types_pkg)
- IMM_WIDTH, 3, instr_format width (from types_pkg)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr  in  DATA_WIDTH  instruction register contents (valid from DECODE onward)
- alu_zero  in  1  ALU result == 0
- mem_ack  in  1  memory completed the current request this cycle
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  request is a store
- addr_src  out  1  0=PC, 1=ALU result (the registered ALU output, alu_out)
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  2  00=PC+4, 01=PC+imm, 10=ALU result (jalr, bit0 cleared)
- reg_write  out  1  register-file write enable
- result_src  out  2  00=alu_out, 01=mem rdata, 10=PC+4, 11=imm
- alu_src_a  out  1  0=rs1, 1=PC
- alu_src_b  out  1  0=rs2, 1=imm
- alu_ctrl  out  ALU_WIDTH  alu_ctrl enum
- imm_src  out  IMM_WIDTH  instr_format enum
- retire  out  1  one-cycle pulse in each instruction's final cycle
- trap  out  1  sticky illegal-instruction flag

Behaviour:
- State register: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs are combinational from the state register and instr.
- While rst=1, every output is forced to 0.
- The first clock edge with rst=1 sets the state to FETCH. rst mid-instruction abandons it, including a pending mem_req. A late mem_ack is ignored.
- FETCH: mem_req=1, mem_we=0, addr_src=0. Stays in FETCH until mem_ack. In the mem_ack cycle: ir_write=1, next state DECODE.
- DECODE: imm_src is driven from the opcode. An illegal opcode or funct3/funct7 goes to TRAP, otherwise to EXEC.
- EXEC, by opcode:
  - R: alu_src_b=0, next WB.
  - I2: alu_src_b=1, imm_src=Imm, next WB.
  - I1 (load): SUM, imm_src=Imm, next MEM.
  - S: SUM, imm_src=Store, next MEM.
  - B: SUB rs1,rs2, imm_src=Branch. Completes in this cycle: pc_write=1, retire=1. pc_src=01 when taken, else 00. Taken is funct3 000 with alu_zero=1, or funct3 001 with alu_zero=0. Next FETCH.
  - U1 (auipc): alu_src_a=1, alu_src_b=1, SUM, imm_src=UpperImm, next WB.
  - U2 (lui): imm_src=UpperImm, next WB.
  - J (jal): imm_src=Jump, next WB.
  - I3 (jalr): SUM rs1+imm, imm_src=Imm, next WB.
- MEM: mem_req=1, addr_src=1, mem_we=1 for S. Stays in MEM until mem_ack.
  - S on ack: pc_write=1, pc_src=00, retire=1, next FETCH.
  - I1 on ack: next WB. The datapath latches rdata on ack.
- WB: reg_write=1, pc_write=1, retire=1, next FETCH.
  - result_src: R/I2/U1 → 00, I1 → 01, J/I3 → 10, U2 → 11.
  - pc_src: J → 01, I3 → 10, all others → 00.
- reg_write is suppressed whenever rd (instr[11:7]) is 0. pc_write and retire are still asserted.
- ALU decode:
  - funct3 000: SUB if R and funct7[5]=1, else SUM.
  - funct3 111: AND.
  - funct3 010: SLT.
  - funct3 001 with funct7=0: SLL.
  - Any other funct3 for R/I2 is illegal.
- Address decode: I1/S require funct3 010 (lw/sw). Other values are illegal.
- TRAP: all enables 0 and trap=1. TRAP is left only by rst.
- mem_ack outside FETCH/MEM is ignored.
- Cycle counts with zero-wait memory:
  - B: 3.
  - R/I2/U/J/I3/S: 4.
  - I1: 5.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset held 3 cycles, then `add x3,x1,x2` (0x002081B3) with mem_ack on the first FETCH cycle → FETCH, DECODE, EXEC, WB. In EXEC, alu_ctrl=000 and alu_src_b=0. In WB, reg_write=1, result_src=00, pc_write=1 and retire=1, all in the 4th cycle.
- `lw x5,8(x1)` (0x0080A283) with mem_ack delayed 2 cycles in MEM → mem_req=1, addr_src=1 and mem_we=0 held for 3 cycles. Then WB with result_src=01. Total 7 cycles.
- `beq x1,x2,+16` (0x00208863): alu_zero=1 → pc_src=01, pc_write=1 and retire=1 in cycle 3, no reg_write. Same instruction with alu_zero=0 → pc_src=00. `bne` with alu_zero=0 → pc_src=01.
- `sub x0,x1,x2` (0x40208033) → alu_ctrl=001, reg_write stays 0 in WB, retire=1.
- Illegal opcode 0x0000007F → TRAP after DECODE, trap=1 and all enables 0 for 10 cycles. rst → FETCH with trap=0.
- rst asserted in MEM of a store while mem_req=1 → next cycle mem_req=0 with mem_we never pulsed after rst. A mem_ack arriving during rst is ignored. Normal FETCH follows.
